// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmitter, one 8-O-1 frame per Send/Sent handshake.
//            Frame = start(0), 8 data bits LSB first, odd parity, stop(1).
//            Sout, Sent and Busy all come straight from flops.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk   in   1  system clock, rising edge
//   rst   in   1  synchronous active-high reset
//   Send  in   1  transmit request (level, four-phase handshake)
//   Din   in   8  byte to send, captured when a frame starts
//   Sout  out  1  serial line, idles high
//   Sent  out  1  frame-complete acknowledge (level, held in ACK)
//   Busy  out  1  high in every state except IDLE
// Build option
//   UART_TX_STOP2_EN  defined: two stop bits (STOP lasts 2*BIT_CYCLES)
// ============================================================================
module uart_tx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Send,
  input  logic [7:0] Din,
  output logic       Sout,
  output logic       Sent,
  output logic       Busy
);

  localparam int          BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam logic [12:0] c_BIT_LAST = 13'(BIT_CYCLES - 1);

`ifdef UART_TX_STOP2_EN
  // The stop phase ends after the bit whose index LSB equals this value.
  localparam logic c_STOP_LAST = 1'b1;
`else
  localparam logic c_STOP_LAST = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_ACK    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [12:0] r_baud_cnt;
  logic [12:0] w_baud_nxt;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  r_shreg;
  logic [7:0]  w_shreg_nxt;
  logic        r_par;
  logic        w_par_nxt;
  logic        r_sout;
  logic        w_sout_nxt;
  logic        r_sent;
  logic        w_sent_nxt;
  logic        r_busy;
  logic        w_busy_nxt;
  logic        w_bit_done;

  assign w_bit_done = (r_baud_cnt == c_BIT_LAST);

  // --------------------------------------------------------------------------
  // State register and all datapath/output flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= 13'd0;
      r_bit_idx  <= 3'd0;
      r_shreg    <= 8'd0;
      r_par      <= 1'b0;
      r_sout     <= 1'b1;
      r_sent     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_shreg    <= w_shreg_nxt;
      r_par      <= w_par_nxt;
      r_sout     <= w_sout_nxt;
      r_sent     <= w_sent_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, datapath and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_par_nxt   = r_par;
    w_idx_nxt   = r_bit_idx;

    case (r_state)
      S_IDLE: begin
        if (Send) begin
          w_state_nxt = S_START;
          w_shreg_nxt = Din;
          w_par_nxt   = ~^Din;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_shreg_nxt = r_shreg >> 1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_PARITY;
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_done) begin
          w_state_nxt = S_STOP;
          w_idx_nxt   = 3'd0;
        end
      end
      S_STOP: begin
        // Bit index is reused to count stop bits in the two-stop build.
        if (w_bit_done) begin
          if (r_bit_idx[0] == c_STOP_LAST) begin
            w_state_nxt = S_ACK;
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_ACK: begin
        if (!Send) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Counter restarts on any state entry and at every bit boundary; it is
    // parked at zero in the states that have no bit timing.
    if ((w_state_nxt != r_state) || w_bit_done ||
        (r_state == S_IDLE) || (r_state == S_ACK)) begin
      w_baud_nxt = 13'd0;
    end else begin
      w_baud_nxt = r_baud_cnt + 13'd1;
    end

    // Outputs are decoded from the next state so the flops present the new
    // line level on the same edge that the state changes.
    case (w_state_nxt)
      S_START:  w_sout_nxt = 1'b0;
      S_DATA:   w_sout_nxt = w_shreg_nxt[0];
      S_PARITY: w_sout_nxt = w_par_nxt;
      default:  w_sout_nxt = 1'b1;
    endcase
    w_sent_nxt = (w_state_nxt == S_ACK);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign Sout = r_sout;
  assign Sent = r_sent;
  assign Busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Scoreboard bench for uart_tx. The stimulus side pushes each
//            expected byte (and its expected start edge) into a queue; an
//            independent line monitor detects start bits, samples mid-bit,
//            and compares against a reference frame built from the byte.
//            A short bit period (16 clocks) keeps the run small.
// Revision : 1.0  initial release
// Build option
//   UART_TX_STOP2_EN  expects two stop bits
// ============================================================================
module tb_uart_tx;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int BC       = CLK_FREQ / BAUD;
`ifdef UART_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int NB = 10 + NSTOP;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       Send = 1'b0;
  logic [7:0] Din  = 8'h00;
  logic       Sout;
  logic       Sent;
  logic       Busy;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    int         exp_start;
    bit         aborted;
  } exp_t;

  exp_t sb[$];

  uart_tx #(
    .CLK_FREQUENCY(CLK_FREQ),
    .BAUD_RATE    (BAUD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .Send(Send),
    .Din (Din),
    .Sout(Sout),
    .Sent(Sent),
    .Busy(Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference frame: bit k is the line level during bit period k.
  function automatic logic [11:0] ref_frame(input logic [7:0] d);
    logic [11:0] f;
    int          ones;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones  += int'(d[i]);
    end
    f[9] = ((ones % 2) == 0);
    return f;
  endfunction

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  task automatic check_frame(input int f);
    exp_t        e;
    logic [11:0] got;
    int          lim;
    int          off;
    bit          early_sent;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL unexpected_frame: start bit at cycle %0d, expected none", f);
      return;
    end
    e          = sb.pop_front();
    chk("start_edge", f, e.exp_start);
    got        = '1;
    early_sent = 1'b0;
    lim        = f + (NB - 1) * BC + BC / 2;
    while (cyc < lim) begin
      @(negedge clk);
      if (!Busy) begin
        chk("abort_flag", e.aborted, 1);
        chk("abort_line", Sout, 1);
        return;
      end
      if (Sent) early_sent = 1'b1;
      off = cyc - f - BC / 2;
      if (off >= 0 && (off % BC) == 0 && (off / BC) < 12) got[off / BC] = Sout;
    end
    chk("abort_flag", e.aborted, 0);
    chk("frame_bits", got, ref_frame(e.data));
    chk("early_sent", early_sent, 0);
    lim = f + NB * BC + 4;
    while (Sent !== 1'b1 && cyc < lim) @(negedge clk);
    chk("sent_time", cyc - f, NB * BC);
    chk("busy_at_sent", Busy, 1);
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && Sout === 1'b0) check_frame(cyc);
      prev = Sout;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus (called at a negedge with the DUT idle)
  // --------------------------------------------------------------------------
  task automatic do_frame(input logic [7:0] d, input bit drop_mid, input int drop_at,
                          input int chg_at, input logic [7:0] d_new, input int hold_extra);
    int st;
    int n;
    bit ok;
    Din  = d;
    Send = 1'b1;
    st   = cyc + 1;
    sb.push_back('{data: d, exp_start: st, aborted: 1'b0});
    n = 0;
    while (Sent !== 1'b1 && n < NB * BC + 8) begin
      @(negedge clk);
      n++;
      if (cyc == st + chg_at) Din = d_new;
      if (drop_mid && cyc == st + drop_at) Send = 1'b0;
    end
    chk("sent_seen", Sent, 1);
    if (!drop_mid) begin
      ok = 1'b1;
      for (int i = 0; i < hold_extra; i++) begin
        @(negedge clk);
        if (Sent !== 1'b1 || Sout !== 1'b1 || Busy !== 1'b1) ok = 1'b0;
      end
      if (hold_extra > 0) chk("ack_hold", ok, 1);
      Send = 1'b0;
    end
    @(negedge clk);
    chk("ack_exit_sent", Sent, 0);
    chk("ack_exit_busy", Busy, 0);
  endtask

  initial begin : stim
    int st;
    bit ok;
    rst  = 1'b1;
    Send = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sout", Sout, 1);
    chk("reset_sent", Sent, 0);
    chk("reset_busy", Busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed frames; the first one changes Din shortly after the start.
    do_frame(8'h41, 1'b0, 0, 10, 8'h3C, 0);
    do_frame(8'h07, 1'b0, 0, -1, 8'h07, 2);
    do_frame(8'hFF, 1'b1, 3 * BC + 5, -1, 8'hFF, 0);

    // Randomized frames, mixing early Send drop and held Send.
    for (int i = 0; i < 8; i++) begin
      do_frame(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(1, 10 * BC)),
               int'($urandom_range(1, 10 * BC)), 8'($urandom), int'($urandom_range(0, 5)));
    end

    // Send held far beyond the frame: exactly one frame, Sent held.
    do_frame(8'h5A, 1'b0, 0, -1, 8'h5A, 3 * NB * BC);

    // Reset in the middle of the data bits.
    Din  = 8'hA5;
    Send = 1'b1;
    st   = cyc + 1;
    sb.push_back('{data: 8'hA5, exp_start: st, aborted: 1'b1});
    while (cyc < st + 5 * BC + 3) @(negedge clk);
    rst  = 1'b1;
    Send = 1'b0;
    @(negedge clk);
    chk("rst_mid_sout", Sout, 1);
    chk("rst_mid_busy", Busy, 0);
    chk("rst_mid_sent", Sent, 0);
    rst = 1'b0;
    ok  = 1'b1;
    repeat (4 * BC) begin
      @(negedge clk);
      if (Sout !== 1'b1) ok = 1'b0;
    end
    chk("idle_after_rst", ok, 1);

    // Send already high while reset is released.
    rst  = 1'b1;
    Send = 1'b1;
    Din  = 8'h99;
    repeat (2) @(negedge clk);
    chk("rst_send_high_sout", Sout, 1);
    rst = 1'b0;
    do_frame(8'hC3, 1'b0, 0, -1, 8'hC3, 1);

    repeat (2 * BC) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
